// File: rtl/microwave_pkg.sv
// microwave_pkg: state encoding, default widths, quick-start digits and BCD check
package microwave_pkg;
  localparam int DEF_DIGIT_W    = 4;
  localparam int DEF_MAX_DIGITS = 3;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ENTRY = 3'd1,
    S_COOK  = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4,
    S_QLOAD = 3'd5
  } state_t;
  localparam logic [DEF_DIGIT_W-1:0] QUICK_DIGITS [3] = '{4'd0, 4'd3, 4'd0};
  function automatic logic is_bcd(input logic [31:0] v);
    return v <= 32'd9;
  endfunction
endpackage

// File: rtl/microwave_if.sv
// microwave_if: keypad/button/door inputs and timer-control outputs of the oven sequencer
interface microwave_if #(parameter int DIGIT_W = 4);
  logic               key_valid;
  logic [DIGIT_W-1:0] key_digit;
  logic               startn;
  logic               stopn;
  logic               door_closed;
  logic               timer_zero;
  logic               timer_loadn;
  logic               timer_en;
  logic [DIGIT_W-1:0] timer_data;
  logic               timer_clrn;
  logic               mag_on;
  logic               done;
  logic [2:0]         state_o;
  modport master (
    input  key_valid, key_digit, startn, stopn, door_closed, timer_zero,
    output timer_loadn, timer_en, timer_data, timer_clrn, mag_on, done, state_o
  );
  modport slave (
    output key_valid, key_digit, startn, stopn, door_closed, timer_zero,
    input  timer_loadn, timer_en, timer_data, timer_clrn, mag_on, done, state_o
  );
endinterface

// File: rtl/btn_edge_n.sv
// btn_edge_n: 2-flop synchronizer plus falling-edge detect for an active-low button
module btn_edge_n (
  input  logic clock,
  input  logic clrn,
  input  logic i_btn_n,
  output logic o_fall
);
  logic r_s1, r_s2, r_s3;
  // released (1) is the idle value so reset never fakes a press
  always_ff @(posedge clock or negedge clrn)
    if (!clrn) {r_s1, r_s2, r_s3} <= 3'b111;
    else {r_s1, r_s2, r_s3} <= {i_btn_n, r_s1, r_s2};
  assign o_fall = r_s3 & ~r_s2;
endmodule

// File: rtl/microwave_ctrl.sv
// microwave_ctrl: keypad/start/stop/door sequencer for the countdown timer; QUICK_START_EN adds 30 s quick start
module microwave_ctrl
  import microwave_pkg::*;
#(
  parameter int DIGIT_W     = DEF_DIGIT_W,
  parameter int MAX_DIGITS  = DEF_MAX_DIGITS,
  parameter int DONE_CYCLES = 8
) (
  input logic         clock,
  input logic         clrn,
  microwave_if.master bus
);
  localparam int CNT_W = $clog2(MAX_DIGITS + 1);
  localparam int DC_W  = (DONE_CYCLES > 1) ? $clog2(DONE_CYCLES) : 1;
  state_t             r_state;
  logic               r_loadn, r_en, r_clrn, r_mag, r_done;
  logic [DIGIT_W-1:0] r_data;
  logic [CNT_W-1:0]   r_cnt;
  logic [DC_W-1:0]    r_dcnt;
`ifdef QUICK_START_EN
  logic [1:0]         r_qidx;
`endif
  logic w_start, w_stop, w_key;
  btn_edge_n u_start (.clock(clock), .clrn(clrn), .i_btn_n(bus.startn), .o_fall(w_start));
  btn_edge_n u_stop  (.clock(clock), .clrn(clrn), .i_btn_n(bus.stopn),  .o_fall(w_stop));
  assign w_key = bus.key_valid & is_bcd(32'(bus.key_digit));
  // one FSM; priority in every state is stop > door open > start > key
  always_ff @(posedge clock or negedge clrn)
    if (!clrn) begin
      r_state <= S_IDLE;
      r_loadn <= 1'b1;
      r_en    <= 1'b0;
      r_data  <= '0;
      r_clrn  <= 1'b0;
      r_mag   <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
      r_dcnt  <= '0;
`ifdef QUICK_START_EN
      r_qidx  <= '0;
`endif
    end else begin
      r_loadn <= 1'b1;
      r_clrn  <= 1'b1;
      case (r_state)
        S_IDLE:
          if (w_stop) r_clrn <= 1'b0;
`ifdef QUICK_START_EN
          else if (w_start && bus.door_closed) begin
            r_state <= S_QLOAD;
            r_qidx  <= '0;
          end
`endif
          else if (w_key) begin
            r_loadn <= 1'b0;
            r_data  <= bus.key_digit;
            r_cnt   <= CNT_W'(1);
            r_state <= S_ENTRY;
          end
        S_ENTRY:
          if (w_stop) begin
            r_clrn  <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else if (w_start) begin
            if (bus.door_closed && !bus.timer_zero) begin
              r_state <= S_COOK;
              r_en    <= 1'b1;
              r_mag   <= 1'b1;
            end
          end else if (w_key && r_cnt < CNT_W'(MAX_DIGITS)) begin
            r_loadn <= 1'b0;
            r_data  <= bus.key_digit;
            r_cnt   <= r_cnt + CNT_W'(1);
          end
        S_COOK:
          if (w_stop || !bus.door_closed) begin
            r_state <= S_PAUSE;
            r_en    <= 1'b0;
            r_mag   <= 1'b0;
          end else if (bus.timer_zero) begin
            r_state <= S_DONE;
            r_en    <= 1'b0;
            r_mag   <= 1'b0;
            r_done  <= 1'b1;
            r_dcnt  <= '0;
          end
        S_PAUSE:
          if (w_stop) begin
            r_clrn  <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else if (w_start && bus.door_closed) begin
            r_state <= S_COOK;
            r_en    <= 1'b1;
            r_mag   <= 1'b1;
          end
        S_DONE:
          if (w_stop || r_dcnt == DC_W'(DONE_CYCLES - 1)) begin
            r_done  <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else r_dcnt <= r_dcnt + DC_W'(1);
`ifdef QUICK_START_EN
        S_QLOAD:
          if (w_stop) begin
            r_clrn  <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else if (r_qidx == 2'd3) begin
            r_state <= bus.door_closed ? S_COOK : S_PAUSE;
            r_en    <= bus.door_closed;
            r_mag   <= bus.door_closed;
          end else begin
            r_loadn <= 1'b0;
            r_data  <= QUICK_DIGITS[r_qidx];
            r_qidx  <= r_qidx + 2'd1;
          end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  assign bus.timer_loadn = r_loadn;
  assign bus.timer_en    = r_en;
  assign bus.timer_data  = r_data;
  assign bus.timer_clrn  = r_clrn;
  assign bus.mag_on      = r_mag & bus.door_closed;
  assign bus.done        = r_done;
  assign bus.state_o     = r_state;
endmodule

// File: tb/tb_microwave_ctrl.sv
// tb_microwave_ctrl: directed self-checking bench for microwave_ctrl
module tb_microwave_ctrl;
  logic clock = 1'b0;
  logic clrn;
  int   checks = 0;
  int   errors = 0;
  int   n;
  microwave_if #(.DIGIT_W(4)) bus();
  microwave_ctrl dut (.clock(clock), .clrn(clrn), .bus(bus));
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic key_load(input logic [3:0] d);
    bus.key_valid = 1'b1;
    bus.key_digit = d;
    @(negedge clock);
    bus.key_valid = 1'b0;
    check("load_strobe", 32'(bus.timer_loadn), 0);
    check("load_data", 32'(bus.timer_data), 32'(d));
    @(negedge clock);
    check("load_single", 32'(bus.timer_loadn), 1);
  endtask

  task automatic key_drop(input logic [3:0] d);
    bus.key_valid = 1'b1;
    bus.key_digit = d;
    @(negedge clock);
    bus.key_valid = 1'b0;
    check("drop_strobe", 32'(bus.timer_loadn), 1);
    @(negedge clock);
    check("drop_after", 32'(bus.timer_loadn), 1);
  endtask

  task automatic press_start();
    bus.startn = 1'b0;
    repeat (3) @(negedge clock);
    bus.startn = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_loadn"}, 32'(bus.timer_loadn), 1);
    check({tag, "_en"}, 32'(bus.timer_en), 0);
    check({tag, "_data"}, 32'(bus.timer_data), 0);
    check({tag, "_tclrn"}, 32'(bus.timer_clrn), 0);
    check({tag, "_mag"}, 32'(bus.mag_on), 0);
    check({tag, "_done"}, 32'(bus.done), 0);
    check({tag, "_state"}, 32'(bus.state_o), 0);
  endtask

  initial begin
    clrn = 1'b0;
    bus.key_valid = 1'b0;
    bus.key_digit = '0;
    bus.startn = 1'b1;
    bus.stopn = 1'b1;
    bus.door_closed = 1'b0;
    bus.timer_zero = 1'b0;
    repeat (2) @(negedge clock);
    check_reset_outputs("rst");
    clrn = 1'b1;
    @(negedge clock);
    check("tclrn_release", 32'(bus.timer_clrn), 1);
    key_load(4'd2);
    key_load(4'd1);
    key_load(4'd5);
    check("entry_state", 32'(bus.state_o), 1);
    key_drop(4'd9);
    bus.door_closed = 1'b1;
    press_start();
    check("cook_state", 32'(bus.state_o), 2);
    check("cook_en", 32'(bus.timer_en), 1);
    check("cook_mag", 32'(bus.mag_on), 1);
    bus.timer_zero = 1'b1;
    n = 0;
    repeat (12) begin
      @(negedge clock);
      if (bus.done) n++;
    end
    check("done_cycles", 32'(n), 8);
    check("done_to_idle", 32'(bus.state_o), 0);
    check("done_en_off", 32'(bus.timer_en), 0);
    bus.timer_zero = 1'b0;
    key_load(4'd1);
    press_start();
    check("cook2_state", 32'(bus.state_o), 2);
    bus.door_closed = 1'b0;
    #1;
    check("door_mag_now", 32'(bus.mag_on), 0);
    @(negedge clock);
    check("door_pause", 32'(bus.state_o), 3);
    check("pause_en", 32'(bus.timer_en), 0);
    bus.door_closed = 1'b1;
    repeat (3) @(negedge clock);
    bus.startn = 1'b0;
    n = 0;
    repeat (3) begin
      @(negedge clock);
      if (!bus.timer_clrn) n++;
    end
    bus.startn = 1'b1;
    check("resume_no_clr", 32'(n), 0);
    check("resume_state", 32'(bus.state_o), 2);
    check("resume_mag", 32'(bus.mag_on), 1);
    bus.door_closed = 1'b0;
    @(negedge clock);
    check("pause2_state", 32'(bus.state_o), 3);
    bus.door_closed = 1'b1;
    @(negedge clock);
    bus.stopn = 1'b0;
    n = 0;
    repeat (25) begin
      @(negedge clock);
      if (!bus.timer_clrn) n++;
    end
    check("stop_clr_pulses", 32'(n), 1);
    check("stop_idle", 32'(bus.state_o), 0);
    bus.stopn = 1'b1;
    repeat (4) @(negedge clock);
    key_load(4'd7);
    check("entry2_state", 32'(bus.state_o), 1);
    bus.timer_zero = 1'b1;
    press_start();
    check("zero_start_ign", 32'(bus.state_o), 1);
    bus.timer_zero = 1'b0;
    repeat (3) @(negedge clock);
    key_drop(4'd12);
    key_load(4'd8);
    key_load(4'd3);
    key_drop(4'd4);
    press_start();
    check("cook3_state", 32'(bus.state_o), 2);
    @(negedge clock);
    #2 clrn = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clock);
    clrn = 1'b1;
    repeat (2) @(negedge clock);
`ifdef QUICK_START_EN
    press_start();
    check("q_state", 32'(bus.state_o), 5);
    @(negedge clock);
    check("q0_loadn", 32'(bus.timer_loadn), 0);
    check("q0_data", 32'(bus.timer_data), 0);
    @(negedge clock);
    check("q1_loadn", 32'(bus.timer_loadn), 0);
    check("q1_data", 32'(bus.timer_data), 3);
    @(negedge clock);
    check("q2_loadn", 32'(bus.timer_loadn), 0);
    check("q2_data", 32'(bus.timer_data), 0);
    @(negedge clock);
    check("q_cook", 32'(bus.state_o), 2);
    check("q_cook_en", 32'(bus.timer_en), 1);
    check("q_cook_loadn", 32'(bus.timer_loadn), 1);
`else
    press_start();
    check("idle_start_ign", 32'(bus.state_o), 0);
    check("idle_start_load", 32'(bus.timer_loadn), 1);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
